// File: rtl/sync_debounce_edge.sv
// Synchronizes a slow asynchronous input, debounces it with a consecutive-sample
// filter, and reports the clean level, edge pulses and a saturating transition count.
module sync_debounce_edge #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             d_async,
  input  logic             enable,
  input  logic             clr_count,
  output logic             q,
  output logic             q_not,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] toggle_count,
  output logic             count_sat
);

  localparam int unsigned TIMER_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {
    STABLE    = 1'b0,
    CANDIDATE = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [TIMER_W-1:0]   timer;
  logic [TIMER_W-1:0]   timer_nxt;
  logic [SYNC_STAGES-1:0] sync_chain;
  logic                 d_sync;
  logic                 accept_c;
  logic                 q_nxt;
  logic                 rise_nxt;
  logic                 fall_nxt;
  logic [CNT_W-1:0]     count_nxt;
  logic                 sat_nxt;

  // Metastability chain; runs regardless of enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_chain <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], d_async};
    end
  end

  assign d_sync = sync_chain[SYNC_STAGES-1];

  // Filter state, debounced level, pulses and counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= STABLE;
      timer        <= '0;
      q            <= RESET_LEVEL;
      q_not        <= ~RESET_LEVEL;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      toggle_count <= '0;
      count_sat    <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      q            <= q_nxt;
      q_not        <= ~q_nxt;
      rise_pulse   <= rise_nxt;
      fall_pulse   <= fall_nxt;
      toggle_count <= count_nxt;
      count_sat    <= sat_nxt;
    end
  end

  // Next-state: a new level is accepted after DEBOUNCE_CYCLES consecutive enabled mismatches.
  always_comb begin
    state_nxt = state;
    timer_nxt = '0;
    accept_c  = 1'b0;
    unique case (state)
      STABLE: begin
        if (enable && (d_sync != q)) begin
          if (DEBOUNCE_CYCLES == 1) begin
            accept_c = 1'b1;
          end else begin
            timer_nxt = TIMER_W'(1);
            state_nxt = CANDIDATE;
          end
        end
      end
      CANDIDATE: begin
        if (!enable || (d_sync == q)) begin
          state_nxt = STABLE;
        end else if ((timer + TIMER_W'(1)) == TIMER_W'(DEBOUNCE_CYCLES)) begin
          accept_c  = 1'b1;
          state_nxt = STABLE;
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      default: state_nxt = STABLE;
    endcase
  end

  // Output and counter updates driven by an accept.
  always_comb begin
    q_nxt     = q;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    count_nxt = toggle_count;
    sat_nxt   = count_sat;
    if (accept_c) begin
      q_nxt    = d_sync;
      rise_nxt = d_sync;
      fall_nxt = ~d_sync;
      if (clr_count) begin
        count_nxt = CNT_W'(1);
        sat_nxt   = 1'b0;
      end else if (&toggle_count) begin
        sat_nxt = 1'b1;
      end else begin
        count_nxt = toggle_count + CNT_W'(1);
      end
    end else if (clr_count) begin
      count_nxt = '0;
      sat_nxt   = 1'b0;
    end
  end

endmodule
